// File: rtl/bit_brick.sv
`default_nettype none

// ============================================================================
// Module   : bit_brick
// Purpose  : 2-bit x 2-bit multiplier primitive. Multiplies an activation by
//            a weight, both unsigned (sel=1) or both signed (sel=0), and
//            registers the 4-bit product with a one-cycle valid strobe.
// Revision : 1.0  initial release
// ============================================================================
module bit_brick (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] a,
    input  logic [1:0] w,
    input  logic       sel,
    output logic [3:0] p,
    output logic       p_valid
);

    // Operands widened to the product width: zero-extended in unsigned mode,
    // sign-extended in signed mode.
    logic [3:0] w_a_ext;
    logic [3:0] w_w_ext;
    logic [3:0] w_prod;

    // Operand extension and product; truncating to 4 bits gives the exact
    // result in both modes because neither range can overflow.
    always_comb begin
        w_a_ext = sel ? {2'b00, a} : {{2{a[1]}}, a};
        w_w_ext = sel ? {2'b00, w} : {{2{w[1]}}, w};
        w_prod  = w_a_ext * w_w_ext;
    end

    // Product register: reset wins over en; p holds while en=0, valid pulses
    // for each accepted operand pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= 4'b0000;
            p_valid <= 1'b0;
        end else begin
            p_valid <= en;
            if (en) begin
                p <= w_prod;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_brick.sv
`default_nettype none

// ============================================================================
// Module   : tb_bit_brick
// Purpose  : Directed self-checking bench for bit_brick.
// Revision : 1.0  initial release
// ============================================================================
module tb_bit_brick;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] a;
    logic [1:0] w;
    logic       sel;
    logic [3:0] p;
    logic       p_valid;

    int tests;
    int fails;

    bit_brick dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .w       (w),
        .sel     (sel),
        .p       (p),
        .p_valid (p_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from integer arithmetic on the operand values.
    function automatic logic [3:0] ref_prod(input logic [1:0] ra, input logic [1:0] rw,
                                            input logic rs);
        int ia;
        int iw;
        int ip;
        ia = int'(ra);
        iw = int'(rw);
        if (!rs) begin
            if (ra[1]) ia = ia - 4;
            if (rw[1]) iw = iw - 4;
        end
        ip = ia * iw;
        return ip[3:0];
    endfunction

    // Apply inputs away from the edge, then sample just after the next edge.
    task automatic step(input logic s_rst, input logic s_en, input logic [1:0] s_a,
                        input logic [1:0] s_w, input logic s_sel);
        @(negedge clk);
        rst = s_rst;
        en  = s_en;
        a   = s_a;
        w   = s_w;
        sel = s_sel;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_p, input logic exp_v);
        tests = tests + 1;
        assert (p === exp_p) else begin
            fails = fails + 1;
            $error("FAIL %s p: observed %b expected %b", tag, p, exp_p);
        end
        tests = tests + 1;
        assert (p_valid === exp_v) else begin
            fails = fails + 1;
            $error("FAIL %s p_valid: observed %b expected %b", tag, p_valid, exp_v);
        end
    endtask

    initial begin
        logic [3:0] e;
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b0; a = 2'b00; w = 2'b00; sel = 1'b1;

        // Reset with en=1 and live operands: reset must win.
        step(1'b1, 1'b1, 2'b11, 2'b11, 1'b1);
        check("reset_edge1", 4'b0000, 1'b0);
        step(1'b1, 1'b1, 2'b11, 2'b11, 1'b1);
        check("reset_edge2", 4'b0000, 1'b0);

        // Unsigned 1*2.
        step(1'b0, 1'b1, 2'b01, 2'b10, 1'b1);
        check("uns_1x2", 4'b0010, 1'b1);

        // Signed 1*(-1), then 1*1; the mode switch lands with no bubble.
        step(1'b0, 1'b1, 2'b01, 2'b11, 1'b0);
        check("sgn_1xm1", 4'b1111, 1'b1);
        step(1'b0, 1'b1, 2'b01, 2'b01, 1'b0);
        check("sgn_1x1", 4'b0001, 1'b1);

        // Corners, alternating modes.
        step(1'b0, 1'b1, 2'b11, 2'b11, 1'b1);
        check("uns_3x3", 4'b1001, 1'b1);
        step(1'b0, 1'b1, 2'b10, 2'b10, 1'b0);
        check("sgn_m2xm2", 4'b0100, 1'b1);
        step(1'b0, 1'b1, 2'b10, 2'b01, 1'b0);
        check("sgn_m2x1", 4'b1110, 1'b1);
        step(1'b0, 1'b1, 2'b11, 2'b11, 1'b0);
        check("sgn_m1xm1", 4'b0001, 1'b1);

        // Hold: en=0 with different operands keeps p, drops valid.
        step(1'b0, 1'b0, 2'b11, 2'b10, 1'b1);
        check("hold1", 4'b0001, 1'b0);
        step(1'b0, 1'b0, 2'b10, 2'b11, 1'b0);
        check("hold2", 4'b0001, 1'b0);

        // Three back-to-back accepted pairs.
        step(1'b0, 1'b1, 2'b10, 2'b11, 1'b1);
        check("b2b_0", 4'b0110, 1'b1);
        step(1'b0, 1'b1, 2'b11, 2'b01, 1'b0);
        check("b2b_1", 4'b1111, 1'b1);
        step(1'b0, 1'b1, 2'b10, 2'b11, 1'b0);
        check("b2b_2", 4'b0010, 1'b1);

        // Exhaustive sweep of (a, w, sel) against the reference model.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            step(1'b0, 1'b1, v[4:3], v[2:1], v[0]);
            e = ref_prod(v[4:3], v[2:1], v[0]);
            check($sformatf("sweep_a%0d_w%0d_s%0d", v[4:3], v[2:1], v[0]), e, 1'b1);
        end

        // Mid-stream reset: product presented at the reset edge is dropped.
        step(1'b0, 1'b1, 2'b11, 2'b11, 1'b1);
        check("pre_rst", 4'b1001, 1'b1);
        step(1'b1, 1'b1, 2'b01, 2'b10, 1'b1);
        check("mid_rst", 4'b0000, 1'b0);
        step(1'b0, 1'b0, 2'b01, 2'b10, 1'b1);
        check("post_rst_idle", 4'b0000, 1'b0);
        step(1'b0, 1'b1, 2'b10, 2'b01, 1'b0);
        check("post_rst_resume", 4'b1110, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
